// File: rtl/vproc_bus_arbiter.sv
// Round-robin arbiter sharing one memory-mapped slave bus among NUM_MASTERS VProc masters.
// A grant is held for a whole access (single word or full burst), and acknowledges go only to the owner.
module vproc_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_WIDTH   = 1,
    parameter int BURST_WIDTH = 12
) (
    input  logic                               Clk,
    input  logic                               nReset,

    input  logic [32*NUM_MASTERS-1:0]          M_Addr,
    input  logic [NUM_MASTERS-1:0]             M_WE,
    input  logic [NUM_MASTERS-1:0]             M_RD,
    input  logic [32*NUM_MASTERS-1:0]          M_DataOut,
    input  logic [BURST_WIDTH*NUM_MASTERS-1:0] M_Burst,
    output logic [32*NUM_MASTERS-1:0]          M_DataIn,
    output logic [NUM_MASTERS-1:0]             M_WRAck,
    output logic [NUM_MASTERS-1:0]             M_RDAck,

    output logic [31:0]                        S_Addr,
    output logic                               S_WE,
    output logic                               S_RD,
    output logic [31:0]                        S_DataOut,
    output logic [BURST_WIDTH-1:0]             S_Burst,
    input  logic [31:0]                        S_DataIn,
    input  logic                               S_WRAck,
    input  logic                               S_RDAck,

    output logic [NUM_MASTERS-1:0]             Grant,
    output logic [IDX_WIDTH-1:0]               GrantIdx
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [NUM_MASTERS-1:0]   grant_q, grant_d;
    logic [IDX_WIDTH-1:0]     grant_idx_q, grant_idx_d;
    logic [IDX_WIDTH-1:0]     last_q, last_d;
    logic [BURST_WIDTH-1:0]   remaining_q, remaining_d;

    logic [NUM_MASTERS-1:0]   req_s;
    logic [IDX_WIDTH:0]       pick_s;
    logic [IDX_WIDTH-1:0]     winner_s;
    logic                     winner_found_s;
    logic [BURST_WIDTH-1:0]   winner_burst_s;
    logic                     owned_s;
    logic                     s_we_s;
    logic                     s_rd_s;
    logic                     complete_s;
    logic                     abort_s;

    // Returns {found, index}: first requester scanning upward from last+1, wrapping at NUM_MASTERS.
    function automatic logic [IDX_WIDTH:0] pick_winner(
        input logic [NUM_MASTERS-1:0] req,
        input logic [IDX_WIDTH-1:0]   last
    );
        logic [IDX_WIDTH:0] result;
        int                 cand;
        result = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = (int'(last) + 1 + k) % NUM_MASTERS;
            if (!result[IDX_WIDTH] && req[cand]) begin
                result = {1'b1, IDX_WIDTH'(cand)};
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Request vector and round-robin winner with its effective burst length.
    always_comb begin
        req_s          = M_WE | M_RD;
        pick_s         = pick_winner(req_s, last_q);
        winner_found_s = pick_s[IDX_WIDTH];
        winner_s       = pick_s[IDX_WIDTH-1:0];
        winner_burst_s = M_Burst[int'(winner_s)*BURST_WIDTH +: BURST_WIDTH];
        if (winner_burst_s == {BURST_WIDTH{1'b0}}) begin
            winner_burst_s = BURST_WIDTH'(1);
        end else begin
            winner_burst_s = winner_burst_s;
        end
    end

    assign owned_s = (state_q == ST_OWNED);

    // Slave-side mux of the owning master; the bus is held quiet while idle.
    always_comb begin
        s_we_s    = 1'b0;
        s_rd_s    = 1'b0;
        S_Addr    = 32'h0000_0000;
        S_DataOut = 32'h0000_0000;
        S_Burst   = {BURST_WIDTH{1'b0}};
        if (owned_s) begin
            s_we_s    = M_WE[grant_idx_q];
            s_rd_s    = M_RD[grant_idx_q];
            S_Addr    = M_Addr[int'(grant_idx_q)*32 +: 32];
            S_DataOut = M_DataOut[int'(grant_idx_q)*32 +: 32];
            S_Burst   = M_Burst[int'(grant_idx_q)*BURST_WIDTH +: BURST_WIDTH];
        end else begin
            s_we_s = 1'b0;
        end
    end

    assign S_WE = s_we_s;
    assign S_RD = s_rd_s;

    // Acknowledges steer only to the owner; stray slave acks while idle are dropped.
    always_comb begin
        M_WRAck = {NUM_MASTERS{1'b0}};
        M_RDAck = {NUM_MASTERS{1'b0}};
        if (owned_s) begin
            M_WRAck[grant_idx_q] = S_WRAck;
            M_RDAck[grant_idx_q] = S_RDAck;
        end else begin
            M_WRAck = {NUM_MASTERS{1'b0}};
        end
    end

    assign M_DataIn = {NUM_MASTERS{S_DataIn}};

    // Simultaneous write and read acks still count as a single word.
    assign complete_s = owned_s & ((s_we_s & S_WRAck) | (s_rd_s & S_RDAck));
    assign abort_s    = owned_s & ~(M_WE[grant_idx_q] | M_RD[grant_idx_q]) & ~complete_s;

    // Next-state logic for ownership, burst countdown and the priority pointer.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        last_d      = last_q;
        remaining_d = remaining_q;
        case (state_q)
            ST_IDLE: begin
                if (winner_found_s) begin
                    state_d     = ST_OWNED;
                    grant_d     = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << winner_s;
                    grant_idx_d = winner_s;
                    remaining_d = winner_burst_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWNED: begin
                if (complete_s && (remaining_q > BURST_WIDTH'(1))) begin
                    remaining_d = remaining_q - BURST_WIDTH'(1);
                end else if (complete_s || abort_s) begin
                    state_d     = ST_IDLE;
                    grant_d     = {NUM_MASTERS{1'b0}};
                    last_d      = grant_idx_q;
                    remaining_d = {BURST_WIDTH{1'b0}};
                end else begin
                    state_d = ST_OWNED;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                grant_d     = {NUM_MASTERS{1'b0}};
                remaining_d = {BURST_WIDTH{1'b0}};
            end
        endcase
    end

    // State registers; the pointer resets to the top master so master 0 wins first.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= ST_IDLE;
            grant_q     <= {NUM_MASTERS{1'b0}};
            grant_idx_q <= {IDX_WIDTH{1'b0}};
            last_q      <= IDX_WIDTH'(NUM_MASTERS - 1);
            remaining_q <= {BURST_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            last_q      <= last_d;
            remaining_q <= remaining_d;
        end
    end

    assign Grant    = grant_q;
    assign GrantIdx = grant_idx_q;

endmodule

// File: tb/tb_vproc_bus_arbiter.sv
// Self-checking bench for vproc_bus_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level round-robin model.
module tb_vproc_bus_arbiter;

    localparam int N  = 3;
    localparam int IW = 2;
    localparam int BW = 12;

    logic            clk = 1'b0;
    logic            n_reset;
    logic [32*N-1:0] m_addr, m_dout, m_din;
    logic [N-1:0]    m_we, m_rd, m_wrack, m_rdack, grant;
    logic [BW*N-1:0] m_burst;
    logic [31:0]     s_addr, s_dout, s_din;
    logic            s_we, s_rd, s_wrack, s_rdack;
    logic [BW-1:0]   s_burst;
    logic [IW-1:0]   grant_idx;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vproc_bus_arbiter #(.NUM_MASTERS(N), .IDX_WIDTH(IW), .BURST_WIDTH(BW)) dut (
        .Clk(clk), .nReset(n_reset),
        .M_Addr(m_addr), .M_WE(m_we), .M_RD(m_rd), .M_DataOut(m_dout), .M_Burst(m_burst),
        .M_DataIn(m_din), .M_WRAck(m_wrack), .M_RDAck(m_rdack),
        .S_Addr(s_addr), .S_WE(s_we), .S_RD(s_rd), .S_DataOut(s_dout), .S_Burst(s_burst),
        .S_DataIn(s_din), .S_WRAck(s_wrack), .S_RDAck(s_rdack),
        .Grant(grant), .GrantIdx(grant_idx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic we, input logic rd, input logic [31:0] a,
                         input logic [31:0] d, input logic [BW-1:0] b);
        m_we[i]             = we;
        m_rd[i]             = rd;
        m_addr[i*32 +: 32]  = a;
        m_dout[i*32 +: 32]  = d;
        m_burst[i*BW +: BW] = b;
    endtask

    task automatic clear_all();
        m_we = '0; m_rd = '0; m_addr = '0; m_dout = '0; m_burst = '0;
        s_wrack = 1'b0; s_rdack = 1'b0; s_din = 32'h0;
    endtask

    task automatic do_reset();
        clear_all();
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        n_reset = 1'b1;
        set_m(1, 1'b1, 1'b0, 32'h300, 32'h55, 12'd0);
        tick();
        n_cmp++;
        if ({grant, s_we, s_addr} !== {3'b010, 1'b1, 32'h300}) begin
            n_fail++; $display("FAIL rst_pre_grant: got %b/%b/%h want 010/1/300", grant, s_we, s_addr);
        end
        #3;
        n_reset = 1'b0;
        #1;
        n_cmp++;
        if ({grant, grant_idx, s_we, s_rd, s_addr, m_wrack} !== {3'b000, 2'd0, 1'b0, 1'b0, 32'h0, 3'b000}) begin
            n_fail++; $display("FAIL rst_async: grant=%b idx=%0d we=%b rd=%b addr=%h wrack=%b want all zero",
                               grant, grant_idx, s_we, s_rd, s_addr, m_wrack);
        end
        clear_all();
        tick();
        n_reset = 1'b1;
        set_m(0, 1'b0, 1'b1, 32'h10, 32'h0, 12'd0);
        set_m(1, 1'b0, 1'b1, 32'h20, 32'h0, 12'd0);
        tick();
        n_cmp++;
        if ({grant, grant_idx} !== {3'b001, 2'd0}) begin
            n_fail++; $display("FAIL rst_priority: grant=%b idx=%0d want 001/0", grant, grant_idx);
        end
        clear_all();
        tick();
        tick();
    endtask

    task automatic test_single_write();
        do_reset();
        set_m(0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 12'd0);
        tick();
        n_cmp++;
        if ({grant, s_we, s_rd, s_addr, s_dout, s_burst, m_wrack} !==
            {3'b001, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 12'd0, 3'b000}) begin
            n_fail++; $display("FAIL sw_bus: grant=%b we=%b rd=%b addr=%h data=%h burst=%0d wrack=%b want 001/1/0/100/deadbeef/0/000",
                               grant, s_we, s_rd, s_addr, s_dout, s_burst, m_wrack);
        end
        tick();
        tick();
        s_wrack = 1'b1;
        #1;
        n_cmp++;
        if ({m_wrack, m_rdack} !== {3'b001, 3'b000}) begin
            n_fail++; $display("FAIL sw_ack: wrack=%b rdack=%b want 001/000", m_wrack, m_rdack);
        end
        tick();
        s_wrack  = 1'b0;
        m_we[0]  = 1'b0;
        #1;
        n_cmp++;
        if ({grant, s_we, m_wrack} !== {3'b000, 1'b0, 3'b000}) begin
            n_fail++; $display("FAIL sw_release: grant=%b we=%b wrack=%b want 000/0/000", grant, s_we, m_wrack);
        end
    endtask

    task automatic test_fairness();
        int served[N];
        int exp_order[4] = '{0, 1, 0, 1};
        bit found;
        for (int i = 0; i < N; i++) served[i] = 0;
        do_reset();
        set_m(0, 1'b0, 1'b1, 32'h40, 32'h0, 12'd0);
        set_m(1, 1'b0, 1'b1, 32'h80, 32'h0, 12'd0);
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            for (int c = 0; c < 8; c++) begin
                if (grant != 3'b000) begin
                    found = 1'b1;
                    break;
                end
                tick();
            end
            n_cmp++;
            if (!found || grant_idx !== IW'(exp_order[k])) begin
                n_fail++; $display("FAIL fair_order%0d: found=%b idx=%0d want %0d", k, found, grant_idx, exp_order[k]);
            end
            s_rdack = 1'b1;
            s_din   = 32'h12345678;
            #1;
            n_cmp++;
            if (m_rdack !== (3'b001 << exp_order[k]) || m_din[exp_order[k]*32 +: 32] !== 32'h12345678) begin
                n_fail++; $display("FAIL fair_ack%0d: rdack=%b din=%h want %b/12345678",
                                   k, m_rdack, m_din[exp_order[k]*32 +: 32], 3'b001 << exp_order[k]);
            end
            tick();
            s_rdack = 1'b0;
            served[exp_order[k]]++;
            if (served[exp_order[k]] == 2) m_rd[exp_order[k]] = 1'b0;
        end
        tick();
    endtask

    task automatic test_burst_hold();
        do_reset();
        set_m(1, 1'b1, 1'b0, 32'h200, 32'hA0000000, 12'd4);
        tick();
        n_cmp++;
        if ({grant, s_burst, s_addr} !== {3'b010, 12'd4, 32'h200}) begin
            n_fail++; $display("FAIL bh_grant: grant=%b burst=%0d addr=%h want 010/4/200", grant, s_burst, s_addr);
        end
        for (int w = 0; w < 4; w++) begin
            s_wrack = 1'b1;
            s_rdack = 1'b1;
            #1;
            n_cmp++;
            if ({m_wrack, m_rdack, s_addr, s_dout} !== {3'b010, 3'b010, 32'h200 + 32'(4*w), 32'hA0000000 + 32'(w)}) begin
                n_fail++; $display("FAIL bh_word%0d: wrack=%b rdack=%b addr=%h data=%h want 010/010/%h/%h",
                                   w, m_wrack, m_rdack, s_addr, s_dout, 32'h200 + 32'(4*w), 32'hA0000000 + 32'(w));
            end
            tick();
            s_wrack = 1'b0;
            s_rdack = 1'b0;
            if (w == 0) set_m(0, 1'b0, 1'b1, 32'h400, 32'h0, 12'd0);
            if (w < 3) begin
                set_m(1, 1'b1, 1'b0, 32'h200 + 32'(4*(w+1)), 32'hA0000000 + 32'(w+1), 12'd4);
                if (w == 1) tick();
                n_cmp++;
                if (grant !== 3'b010) begin
                    n_fail++; $display("FAIL bh_hold%0d: grant=%b want 010", w, grant);
                end
            end else begin
                n_cmp++;
                if (grant !== 3'b000) begin
                    n_fail++; $display("FAIL bh_end: grant=%b want 000", grant);
                end
                m_we[1] = 1'b0;
            end
        end
        tick();
        n_cmp++;
        if ({grant, grant_idx} !== {3'b001, 2'd0}) begin
            n_fail++; $display("FAIL bh_next: grant=%b idx=%0d want 001/0", grant, grant_idx);
        end
        s_rdack = 1'b1;
        #1;
        n_cmp++;
        if (m_rdack !== 3'b001) begin
            n_fail++; $display("FAIL bh_m0ack: rdack=%b want 001", m_rdack);
        end
        tick();
        s_rdack = 1'b0;
        m_rd[0] = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        do_reset();
        set_m(0, 1'b0, 1'b1, 32'h500, 32'h0, 12'd5);
        tick();
        set_m(1, 1'b1, 1'b0, 32'h600, 32'h77, 12'd0);
        for (int a = 0; a < 2; a++) begin
            s_rdack = 1'b1;
            #1;
            n_cmp++;
            if (m_rdack !== 3'b001) begin
                n_fail++; $display("FAIL ab_ack%0d: rdack=%b want 001", a, m_rdack);
            end
            tick();
            s_rdack = 1'b0;
            n_cmp++;
            if (grant !== 3'b001) begin
                n_fail++; $display("FAIL ab_hold%0d: grant=%b want 001", a, grant);
            end
        end
        m_rd[0] = 1'b0;
        tick();
        n_cmp++;
        if (grant !== 3'b000) begin
            n_fail++; $display("FAIL ab_idle: grant=%b want 000", grant);
        end
        tick();
        n_cmp++;
        if ({grant, grant_idx, s_we, s_addr} !== {3'b010, 2'd1, 1'b1, 32'h600}) begin
            n_fail++; $display("FAIL ab_next: grant=%b idx=%0d we=%b addr=%h want 010/1/1/600", grant, grant_idx, s_we, s_addr);
        end
        s_wrack = 1'b1;
        tick();
        s_wrack = 1'b0;
        m_we[1] = 1'b0;
        tick();
    endtask

    task automatic test_stray_ack();
        do_reset();
        s_rdack = 1'b1;
        s_wrack = 1'b1;
        s_din   = $urandom;
        #1;
        n_cmp++;
        if ({m_rdack, m_wrack, grant, s_rd, s_we} !== 11'd0) begin
            n_fail++; $display("FAIL stray_fwd: rdack=%b wrack=%b grant=%b rd=%b we=%b want all zero",
                               m_rdack, m_wrack, grant, s_rd, s_we);
        end
        tick();
        s_rdack = 1'b0;
        s_wrack = 1'b0;
        n_cmp++;
        if ({grant, grant_idx} !== {3'b000, 2'd0}) begin
            n_fail++; $display("FAIL stray_state: grant=%b idx=%0d want 000/0", grant, grant_idx);
        end
        set_m(0, 1'b0, 1'b1, 32'h8, 32'h0, 12'd0);
        set_m(1, 1'b0, 1'b1, 32'hC, 32'h0, 12'd0);
        tick();
        n_cmp++;
        if (grant !== 3'b001) begin
            n_fail++; $display("FAIL stray_prio: grant=%b want 001", grant);
        end
        clear_all();
        tick();
        tick();
    endtask

    task automatic test_random();
        int owner = -1;
        int last  = N - 1;
        int gidx  = 0;
        int left  = 0;
        bit act[N];
        bit isw[N];
        int words[N];
        logic [BW-1:0] bur[N];
        logic [N-1:0] eg, ewr, erd;
        logic [31:0] ea, ed;
        logic [BW-1:0] eb;
        logic ewe, erdy, comp, found;
        int cand;
        for (int i = 0; i < N; i++) begin
            act[i] = 1'b0; isw[i] = 1'b0; words[i] = 0; bur[i] = '0;
        end
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (act[i] && $urandom_range(0, 39) == 0) begin
                    act[i] = 1'b0;
                end else if (!act[i] && $urandom_range(0, 3) == 0) begin
                    act[i]   = 1'b1;
                    isw[i]   = 1'($urandom_range(0, 1));
                    bur[i]   = BW'($urandom_range(0, 5));
                    words[i] = (bur[i] == '0) ? 1 : int'(bur[i]);
                end
                set_m(i, act[i] & isw[i], act[i] & ~isw[i], $urandom, $urandom, bur[i]);
            end
            s_wrack = 1'($urandom_range(0, 1));
            s_rdack = 1'($urandom_range(0, 1));
            s_din   = $urandom;
            #1;
            eg = '0; ewr = '0; erd = '0; ea = '0; ed = '0; eb = '0; ewe = 1'b0; erdy = 1'b0;
            if (owner >= 0) begin
                eg[owner]  = 1'b1;
                ewr[owner] = s_wrack;
                erd[owner] = s_rdack;
                ea   = m_addr[owner*32 +: 32];
                ed   = m_dout[owner*32 +: 32];
                eb   = m_burst[owner*BW +: BW];
                ewe  = m_we[owner];
                erdy = m_rd[owner];
            end
            n_cmp++;
            if ({grant, grant_idx} !== {eg, IW'(gidx)}) begin
                n_fail++; $display("FAIL rnd_grant@%0d: grant=%b idx=%0d want %b/%0d", cyc, grant, grant_idx, eg, gidx);
            end
            n_cmp++;
            if ({s_we, s_rd, s_addr, s_dout, s_burst} !== {ewe, erdy, ea, ed, eb}) begin
                n_fail++; $display("FAIL rnd_bus@%0d: we=%b rd=%b addr=%h data=%h burst=%0d want %b/%b/%h/%h/%0d",
                                   cyc, s_we, s_rd, s_addr, s_dout, s_burst, ewe, erdy, ea, ed, eb);
            end
            n_cmp++;
            if ({m_wrack, m_rdack} !== {ewr, erd}) begin
                n_fail++; $display("FAIL rnd_ack@%0d: wrack=%b rdack=%b want %b/%b", cyc, m_wrack, m_rdack, ewr, erd);
            end
            n_cmp++;
            if (m_din !== {N{s_din}}) begin
                n_fail++; $display("FAIL rnd_din@%0d: din=%h want %h", cyc, m_din, {N{s_din}});
            end
            if (owner < 0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    cand = (last + 1 + k) % N;
                    if (!found && (m_we[cand] || m_rd[cand])) begin
                        found = 1'b1;
                        owner = cand;
                        gidx  = cand;
                        left  = (bur[cand] == '0) ? 1 : int'(bur[cand]);
                    end
                end
            end else begin
                comp = (m_we[owner] && s_wrack) || (m_rd[owner] && s_rdack);
                if (comp) begin
                    words[owner]--;
                    if (words[owner] == 0) act[owner] = 1'b0;
                    if (left > 1) begin
                        left--;
                    end else begin
                        last  = owner;
                        owner = -1;
                    end
                end else if (!m_we[owner] && !m_rd[owner]) begin
                    last  = owner;
                    owner = -1;
                end
            end
            tick();
        end
        clear_all();
        tick();
        tick();
    endtask

    initial begin
        n_reset = 1'b0;
        clear_all();
        tick();
        tick();
        test_reset();
        test_single_write();
        test_fairness();
        test_burst_hold();
        test_abort();
        test_stray_ack();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule

// File: doc/vproc_bus_arbiter.md
Name: vproc_bus_arbiter

Overview:
- Shares one memory-mapped slave bus between NUM_MASTERS VProc bus masters using round-robin arbitration.
- A grant covers a whole access: one single transfer, or all words of a burst.
- Sits between several VProc instances and a single shared memory/peripheral model.
- Slave-side acknowledges are routed back only to the granted master.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- IDX_WIDTH, 1, width of the grant index; must equal clog2(NUM_MASTERS).
- BURST_WIDTH, 12, width of each master's burst-count field.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- nReset  in  1  asynchronous, active-low reset.
- M_Addr  in  32*NUM_MASTERS  per-master address; master i occupies bits [32i+31:32i].
- M_WE  in  NUM_MASTERS  per-master write strobe.
- M_RD  in  NUM_MASTERS  per-master read strobe.
- M_DataOut  in  32*NUM_MASTERS  per-master write data.
- M_Burst  in  BURST_WIDTH*NUM_MASTERS  per-master burst word count; 0 or 1 means a single transfer.
- M_DataIn  out  32*NUM_MASTERS  read data to masters; S_DataIn is broadcast to every slice.
- M_WRAck  out  NUM_MASTERS  write acknowledge per master.
- M_RDAck  out  NUM_MASTERS  read acknowledge per master.
- S_Addr  out  32  slave address.
- S_WE  out  1  slave write strobe.
- S_RD  out  1  slave read strobe.
- S_DataOut  out  32  slave write data.
- S_Burst  out  BURST_WIDTH  burst count of the granted master.
- S_DataIn  in  32  slave read data.
- S_WRAck  in  1  slave write acknowledge.
- S_RDAck  in  1  slave read acknowledge.
- Grant  out  NUM_MASTERS  one-hot grant, registered.
- GrantIdx  out  IDX_WIDTH  index of the granted master, registered.

Behaviour:
- Request: master i requests when M_WE[i] | M_RD[i]. Masters hold their strobes until acknowledged and keep them high across the words of a burst.
- Reset (nReset low, asynchronous):
  - State=IDLE; Grant=0; GrantIdx=0; Remaining=0.
  - Priority pointer Last=NUM_MASTERS-1, so master 0 has first priority.
  - All S_* outputs and all M_WRAck/M_RDAck are 0.
- State machine has two states, IDLE and OWNED.
  - IDLE, at least one request at the rising edge:
    - Winner = first requester searching from (Last+1) mod NUM_MASTERS upward, wrapping.
    - Register Grant, GrantIdx and Remaining = max(M_Burst[winner], 1).
    - Go to OWNED.
  - IDLE, no requests: remain in IDLE.
  - OWNED:
    - S_Addr, S_WE, S_RD, S_DataOut and S_Burst are a combinational mux of the granted master's inputs.
    - M_WRAck[GrantIdx] = S_WRAck and M_RDAck[GrantIdx] = S_RDAck, combinationally. All other acknowledge bits are 0.
    - A transfer completes on an edge where (S_WE & S_WRAck) | (S_RD & S_RDAck). If both acknowledges are high, it counts as one transfer.
    - On a completing edge with Remaining>1: Remaining decrements.
    - On a completing edge with Remaining==1: go to IDLE, set Last=GrantIdx, clear Grant to 0. GrantIdx holds its value.
    - Abort: if the granted master has both strobes low at an edge with no completion, go to IDLE next edge and set Last=GrantIdx.
  - In IDLE, S_WE=S_RD=0, S_Addr=0, S_DataOut=0, S_Burst=0, and slave acknowledges are ignored and never forwarded.
- Latency:
  - A request present at edge N gives Grant at edge N; the slave sees the access in the following cycle.
  - After the final acknowledge there is exactly one IDLE cycle before the next grant. Minimum arbitration turnaround is 1 cycle.
- Burst addressing: address increment is the master's responsibility; the arbiter passes M_Addr through unchanged.
- Requests arriving while OWNED wait. A grant is never pre-empted mid-burst.
- Remaining is BURST_WIDTH bits wide; the maximum burst of 4095 is never exceeded.

Test Plan:
1. Reset: assert nReset low mid-cycle -> Grant=0, S_WE=S_RD=0, S_Addr=0 immediately; after release, master 0 has priority.
2. Single write: master 0 writes Addr 0x100, data 0xDEADBEEF, Burst=0; slave acks 3 cycles later -> S_DataOut=0xDEADBEEF, M_WRAck=2'b01 for one cycle, Grant returns to 0 on the following edge.
3. Fairness: masters 0 and 1 each issue a single read simultaneously, repeated twice with slave returning 0x12345678 -> order of service is 0,1,0,1; M_DataIn slice of master 1 = 0x12345678 at its ack.
4. Burst hold: master 1 writes with Burst=4 starting at Addr 0x200; master 0 requests after the first word -> master 0 is not granted until the edge after the 4th S_WRAck; no acknowledge ever reaches master 0 during the burst.
5. Abort: master 0 read with Burst=5 drops M_RD after 2 acks -> state IDLE next edge; a pending master 1 request is granted on the following edge.
6. Stray acknowledge: pulse S_RDAck in IDLE -> all M_RDAck stay 0 and the state is unchanged.
